// File: rtl/regfile_wb_if.sv
// Signal bundle between execute/memory, decode and the register-file write port.
// The master drives results and queries; the slave is the write-back controller.
interface regfile_wb_if #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32
);
    logic                   alu_valid;
    logic [4:0]             alu_rd;
    logic [DATA_W-1:0]      alu_data;
    logic                   ld_valid;
    logic                   ld_ready;
    logic [4:0]             ld_rd;
    logic [DATA_W-1:0]      ld_data;
    logic                   issue_ld;
    logic [4:0]             issue_rd;
    logic [4:0]             rs1;
    logic [4:0]             rs2;
    logic                   stall_rs1;
    logic                   stall_rs2;
    logic                   reg_write;
    logic [4:0]             wr_addr;
    logic [DATA_W-1:0]      wr_data;
    logic [$clog2(DEPTH):0] pending;

    modport master (
        output alu_valid, alu_rd, alu_data,
        output ld_valid, ld_rd, ld_data,
        output issue_ld, issue_rd, rs1, rs2,
        input  ld_ready, stall_rs1, stall_rs2,
        input  reg_write, wr_addr, wr_data, pending
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  ld_valid, ld_rd, ld_data,
        input  issue_ld, issue_rd, rs1, rs2,
        output ld_ready, stall_rs1, stall_rs2,
        output reg_write, wr_addr, wr_data, pending
    );
endinterface

// File: rtl/regfile_wb_ctrl.sv
// Register-file write-port owner: merges ALU results with FIFO-buffered load
// results and keeps a per-register busy scoreboard for decode operand stalls.
module regfile_wb_ctrl #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32
) (
    input  logic        clk,
    input  logic        reset,
    regfile_wb_if.slave wb
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [DATA_W-1:0] fifo_data [DEPTH];
    logic [4:0]        fifo_rd   [DEPTH];
    logic [AW-1:0]     rd_ptr;
    logic [AW-1:0]     wr_ptr;
    logic [CW-1:0]     count;
    logic              push;
    logic              pop;
    logic              alu_win;
    logic [4:0]        head_rd;
    logic [DATA_W-1:0] head_data;

    logic              vld_p1;
    logic              fifo_src_p1;
    logic [4:0]        addr_p1;
    logic [DATA_W-1:0] data_p1;

    logic [31:0]       busy;
    logic [31:0]       busy_nxt;

    // An ALU result to x0 is dropped and does not block the FIFO.
    assign alu_win     = wb.alu_valid && (wb.alu_rd != 5'd0);
    assign wb.ld_ready = (count < DEPTH_C);
    assign push        = wb.ld_valid && wb.ld_ready;
    assign pop         = !alu_win && (count != '0);
    assign head_rd     = fifo_rd[rd_ptr];
    assign head_data   = fifo_data[rd_ptr];

    // Stage p0: load-result FIFO storage and occupancy
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_rd[wr_ptr]   <= wb.ld_rd;
            fifo_data[wr_ptr] <= wb.ld_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Stage p1: registered write port, ALU first, FIFO head otherwise
    always_ff @(posedge clk) begin
        if (!reset) begin
            vld_p1      <= 1'b0;
            fifo_src_p1 <= 1'b0;
            addr_p1     <= '0;
            data_p1     <= '0;
        end else if (alu_win) begin
            vld_p1      <= 1'b1;
            fifo_src_p1 <= 1'b0;
            addr_p1     <= wb.alu_rd;
            data_p1     <= wb.alu_data;
        end else if (pop) begin
            vld_p1      <= (head_rd != 5'd0);
            fifo_src_p1 <= 1'b1;
            if (head_rd != 5'd0) begin
                addr_p1 <= head_rd;
                data_p1 <= head_data;
            end
        end else begin
            vld_p1      <= 1'b0;
            fifo_src_p1 <= 1'b0;
        end
    end

    // A newly issued load to the same register outranks the write retiring now.
    always_comb begin
        busy_nxt = busy;
        if (vld_p1 && fifo_src_p1) begin
            busy_nxt[addr_p1] = 1'b0;
        end
        if (wb.issue_ld && (wb.issue_rd != 5'd0)) begin
            busy_nxt[wb.issue_rd] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end

    assign wb.stall_rs1 = busy[wb.rs1];
    assign wb.stall_rs2 = busy[wb.rs2];
    assign wb.reg_write = vld_p1;
    assign wb.wr_addr   = addr_p1;
    assign wb.wr_data   = data_p1;
    assign wb.pending   = count;
endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Bench for regfile_wb_ctrl: directed scenarios then random traffic, with a
// queue-based reference model feeding a scoreboard drained by a monitor.
module tb_regfile_wb_ctrl;
    localparam int DEPTH  = 4;
    localparam int DATA_W = 32;

    typedef struct packed {
        logic [4:0]        rd;
        logic [DATA_W-1:0] data;
    } ent_t;

    logic clk;
    logic reset;

    regfile_wb_if #(.DEPTH(DEPTH), .DATA_W(DATA_W)) bus ();

    regfile_wb_ctrl #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
        .clk   (clk),
        .reset (reset),
        .wb    (bus)
    );

    int   n_checks = 0;
    int   n_fail   = 0;
    bit   started  = 0;
    ent_t mq[$];
    ent_t expq[$];
    ent_t mon_e;
    logic [31:0] busy_m = '0;
    logic        m_out_v = 1'b0;
    logic        m_out_fifo = 1'b0;
    logic [4:0]  m_out_addr = '0;
    bit          m_acc = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: applies the coming clock edge to the abstract state.
    task automatic model_step();
        ent_t e;
        bit   alu_w;
        m_acc = 0;
        if (reset == 1'b0) begin
            mq.delete();
            expq.delete();
            busy_m     = '0;
            m_out_v    = 1'b0;
            m_out_fifo = 1'b0;
            m_out_addr = '0;
            return;
        end
        if (m_out_v && m_out_fifo) busy_m[m_out_addr] = 1'b0;
        if (bus.issue_ld && bus.issue_rd != 5'd0) busy_m[bus.issue_rd] = 1'b1;
        m_acc = bus.ld_valid && (mq.size() < DEPTH);
        alu_w = bus.alu_valid && (bus.alu_rd != 5'd0);
        m_out_v    = 1'b0;
        m_out_fifo = 1'b0;
        if (alu_w) begin
            m_out_v    = 1'b1;
            m_out_addr = bus.alu_rd;
            e.rd       = bus.alu_rd;
            e.data     = bus.alu_data;
            expq.push_back(e);
        end else if (mq.size() != 0) begin
            e          = mq.pop_front();
            m_out_fifo = 1'b1;
            m_out_v    = (e.rd != 5'd0);
            m_out_addr = e.rd;
            if (m_out_v) expq.push_back(e);
        end
        if (m_acc) begin
            e.rd   = bus.ld_rd;
            e.data = bus.ld_data;
            mq.push_back(e);
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        bus.alu_valid = 1'b0;
        bus.ld_valid  = 1'b0;
        bus.issue_ld  = 1'b0;
    endtask

    // Monitor: drains the scoreboard on every presented write, checks status outputs.
    always @(posedge clk) begin
        #1;
        if (started) begin
            chk("reg_write", 64'(bus.reg_write), 64'(m_out_v));
            if (bus.reg_write === 1'b1) begin
                n_checks++;
                if (expq.size() == 0) begin
                    n_fail++;
                    $display("FAIL wr_unexpected: write x%0d=0x%0h, want no write at %0t",
                             bus.wr_addr, bus.wr_data, $time);
                end else begin
                    mon_e = expq.pop_front();
                    chk("wr_addr", 64'(bus.wr_addr), 64'(mon_e.rd));
                    chk("wr_data", 64'(bus.wr_data), 64'(mon_e.data));
                end
            end
            chk("pending", 64'(bus.pending), 64'(mq.size()));
            chk("ld_ready", 64'(bus.ld_ready), 64'(mq.size() < DEPTH));
            chk("stall_rs1", 64'(bus.stall_rs1), 64'(busy_m[bus.rs1]));
            chk("stall_rs2", 64'(bus.stall_rs2), 64'(busy_m[bus.rs2]));
        end
    end

    initial begin
        reset         = 1'b0;
        bus.alu_valid = 1'b1;
        bus.alu_rd    = 5'd3;
        bus.alu_data  = 32'hAAAA5555;
        bus.ld_valid  = 1'b1;
        bus.ld_rd     = 5'd4;
        bus.ld_data   = 32'h0BAD0BAD;
        bus.issue_ld  = 1'b1;
        bus.issue_rd  = 5'd6;
        bus.rs1       = 5'd6;
        bus.rs2       = 5'd3;
        @(negedge clk);
        started = 1;

        // Reset held two cycles with traffic present
        cycle();
        cycle();
        chk("rst_reg_write", 64'(bus.reg_write), 64'd0);
        chk("rst_pending", 64'(bus.pending), 64'd0);
        chk("rst_ld_ready", 64'(bus.ld_ready), 64'd1);
        chk("rst_stall_rs1", 64'(bus.stall_rs1), 64'd0);
        chk("rst_stall_rs2", 64'(bus.stall_rs2), 64'd0);
        chk("rst_wr_addr", 64'(bus.wr_addr), 64'd0);
        chk("rst_wr_data", 64'(bus.wr_data), 64'd0);

        // ALU path, then ALU to x0
        reset = 1'b1;
        idle();
        bus.rs1 = 5'd0;
        bus.rs2 = 5'd0;
        cycle();
        bus.alu_valid = 1'b1;
        bus.alu_rd    = 5'd5;
        bus.alu_data  = 32'hDEADBEEF;
        cycle();
        chk("alu_we", 64'(bus.reg_write), 64'd1);
        chk("alu_addr", 64'(bus.wr_addr), 64'd5);
        chk("alu_data", 64'(bus.wr_data), 64'hDEADBEEF);
        bus.alu_rd   = 5'd0;
        bus.alu_data = 32'h12345678;
        cycle();
        chk("alu_x0_we", 64'(bus.reg_write), 64'd0);
        idle();

        // Load plus scoreboard
        bus.issue_ld = 1'b1;
        bus.issue_rd = 5'd7;
        bus.rs1      = 5'd7;
        cycle();
        idle();
        chk("ld_stall_set", 64'(bus.stall_rs1), 64'd1);
        repeat (3) cycle();
        bus.ld_valid = 1'b1;
        bus.ld_rd    = 5'd7;
        bus.ld_data  = 32'h00001234;
        cycle();
        idle();
        chk("ld_lat_n1", 64'(bus.reg_write), 64'd0);
        cycle();
        chk("ld_lat_we", 64'(bus.reg_write), 64'd1);
        chk("ld_lat_addr", 64'(bus.wr_addr), 64'd7);
        chk("ld_lat_data", 64'(bus.wr_data), 64'h1234);
        chk("ld_stall_hold", 64'(bus.stall_rs1), 64'd1);
        cycle();
        chk("ld_stall_clr", 64'(bus.stall_rs1), 64'd0);

        // ALU collides with a waiting FIFO head for three cycles
        bus.issue_ld = 1'b1;
        bus.issue_rd = 5'd9;
        bus.ld_valid = 1'b1;
        bus.ld_rd    = 5'd9;
        bus.ld_data  = 32'h00009999;
        cycle();
        idle();
        for (int i = 0; i < 3; i++) begin
            bus.alu_valid = 1'b1;
            bus.alu_rd    = 5'(10 + i);
            bus.alu_data  = $urandom;
            cycle();
            chk("col_alu_addr", 64'(bus.wr_addr), 64'(10 + i));
        end
        idle();
        cycle();
        chk("col_ld_addr", 64'(bus.wr_addr), 64'd9);
        chk("col_ld_data", 64'(bus.wr_data), 64'h9999);

        // Fill the FIFO behind continuous ALU traffic
        bus.alu_valid = 1'b1;
        bus.alu_rd    = 5'd20;
        for (int i = 1; i <= 4; i++) begin
            bus.alu_data = $urandom;
            bus.ld_valid = 1'b1;
            bus.ld_rd    = 5'(i);
            bus.ld_data  = 32'(i * 8'h11);
            cycle();
        end
        chk("full_pending", 64'(bus.pending), 64'd4);
        chk("full_ready", 64'(bus.ld_ready), 64'd0);
        bus.ld_rd   = 5'd5;
        bus.ld_data = 32'h55;
        cycle();
        cycle();
        chk("full_hold_pending", 64'(bus.pending), 64'd4);
        bus.alu_valid = 1'b0;
        cycle();
        chk("full_first_pop", 64'(bus.wr_addr), 64'd1);
        chk("full_no_same_cycle_push", 64'(bus.pending), 64'd3);
        for (int k = 0; k < 4 && bus.ld_valid; k++) begin
            cycle();
            if (m_acc) bus.ld_valid = 1'b0;
        end
        idle();
        repeat (6) cycle();

        // Set and clear of the same register at one edge
        bus.issue_ld = 1'b1;
        bus.issue_rd = 5'd12;
        bus.rs2      = 5'd12;
        cycle();
        idle();
        bus.ld_valid = 1'b1;
        bus.ld_rd    = 5'd12;
        bus.ld_data  = 32'h0000C0DE;
        cycle();
        idle();
        cycle();
        chk("race_we", 64'(bus.reg_write), 64'd1);
        chk("race_addr", 64'(bus.wr_addr), 64'd12);
        bus.issue_ld = 1'b1;
        bus.issue_rd = 5'd12;
        cycle();
        idle();
        chk("race_stall", 64'(bus.stall_rs2), 64'd1);
        repeat (2) cycle();
        chk("race_stall_persist", 64'(bus.stall_rs2), 64'd1);

        // Reset while the FIFO holds three loads
        bus.issue_ld  = 1'b1;
        bus.issue_rd  = 5'd3;
        bus.rs1       = 5'd3;
        bus.alu_valid = 1'b1;
        bus.alu_rd    = 5'd21;
        bus.ld_valid  = 1'b1;
        bus.ld_rd     = 5'd3;
        bus.ld_data   = 32'h33;
        cycle();
        bus.issue_ld = 1'b0;
        bus.ld_rd    = 5'd13;
        cycle();
        bus.ld_rd    = 5'd14;
        cycle();
        chk("mid_pending", 64'(bus.pending), 64'd3);
        chk("mid_stall", 64'(bus.stall_rs1), 64'd1);
        idle();
        reset = 1'b0;
        cycle();
        reset = 1'b1;
        chk("mid_rst_pending", 64'(bus.pending), 64'd0);
        chk("mid_rst_stall", 64'(bus.stall_rs1), 64'd0);
        chk("mid_rst_we", 64'(bus.reg_write), 64'd0);
        repeat (3) cycle();
        chk("mid_rst_quiet", 64'(bus.reg_write), 64'd0);

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
            if (!bus.ld_valid || m_acc) begin
                bus.ld_valid = ($urandom_range(0, 2) == 0);
                bus.ld_rd    = 5'($urandom_range(0, 31));
                bus.ld_data  = $urandom;
            end
            bus.alu_rd    = 5'($urandom_range(0, 31));
            bus.alu_data  = $urandom;
            bus.alu_valid = ($urandom_range(0, 1) == 1) && !busy_m[bus.alu_rd];
            bus.issue_ld  = ($urandom_range(0, 3) == 0);
            bus.issue_rd  = 5'($urandom_range(0, 31));
            bus.rs1       = 5'($urandom_range(0, 31));
            bus.rs2       = 5'($urandom_range(0, 31));
            cycle();
        end
        reset = 1'b1;
        idle();
        repeat (12) cycle();
        chk("scoreboard_drained", 64'(expq.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
